// File: rtl/mux21_32.sv
// 2:1 word multiplexer with a zero-latency combinational output and
// registered copies of the result and select for pipelined consumers.
module mux21_32 #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic             select,
   output logic [WIDTH-1:0] output_data,
   output logic [WIDTH-1:0] output_data_q,
   output logic             select_q,
   output logic             select_changed
);

   // Plain conditional operator: with an X select, bits on which the two
   // operands agree still resolve to the common value.
   assign output_data = select ? data1 : data0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         output_data_q  <= RESET_VALUE;
         select_q       <= 1'b0;
         select_changed <= 1'b0;
      end else begin
         output_data_q  <= output_data;
         select_q       <= select;
         select_changed <= (select != select_q);
      end
   end

endmodule

// File: tb/tb_mux21_32.sv
// Self-checking bench for mux21_32: directed boundary cases plus random
// traffic compared against a behavioural model of the mux and its registers.
module tb_mux21_32;

   logic        clk;
   logic        rst_n;
   logic [31:0] data0;
   logic [31:0] data1;
   logic        select;
   logic [31:0] output_data;
   logic [31:0] output_data_q;
   logic        select_q;
   logic        select_changed;

   int checks = 0;
   int errors = 0;
   bit clk_en = 0;

   logic [31:0] m_q;
   logic        m_sel;
   logic        m_chg;

   mux21_32 #(.WIDTH(32), .RESET_VALUE(32'h0000_0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data0         (data0),
      .data1         (data1),
      .select        (select),
      .output_data   (output_data),
      .output_data_q (output_data_q),
      .select_q      (select_q),
      .select_changed(select_changed)
   );

   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   // Reference mux expressed as masked bitwise selection.
   function automatic logic [31:0] ref_mux(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      logic [31:0] m;
      m = {32{s}};
      return (a & ~m) | (b & m);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, ".q"},   output_data_q,          m_q);
      chk({tag, ".sq"},  {31'b0, select_q},       {31'b0, m_sel});
      chk({tag, ".chg"}, {31'b0, select_changed}, {31'b0, m_chg});
   endtask

   task automatic model_reset();
      m_q   = 32'h0;
      m_sel = 1'b0;
      m_chg = 1'b0;
   endtask

   // Advance one clock, update the model with what should have been captured,
   // then sample the DUT 1 ns after the edge.
   task automatic tick(input string tag);
      logic [31:0] nxt;
      logic        ns;
      nxt = ref_mux(data0, data1, select);
      ns  = select;
      @(posedge clk);
      if (rst_n === 1'b1) begin
         m_chg = (ns != m_sel);
         m_q   = nxt;
         m_sel = ns;
      end else begin
         model_reset();
      end
      #1;
      chk_regs(tag);
   endtask

   initial begin
      // Combinational path with clk and rst_n left untouched.
      data0  = 32'h1234_5678;
      data1  = 32'h8765_4321;
      select = 1'b0;
      #10 chk("comb_s0", output_data, 32'h1234_5678);
      select = 1'b1;
      #10 chk("comb_s1", output_data, 32'h8765_4321);
      select = 1'b0;
      #10 chk("comb_s0b", output_data, 32'h1234_5678);

      data0 = 32'hFFFF_FFFF; data1 = 32'h0000_0000; select = 1'b0;
      #1 chk("ones_s0", output_data, 32'hFFFF_FFFF);
      select = 1'b1;
      #1 chk("ones_s1", output_data, 32'h0000_0000);
      data0 = 32'hAAAA_AAAA; data1 = 32'h5555_5555; select = 1'b0;
      #1 chk("alt_s0", output_data, 32'hAAAA_AAAA);
      select = 1'b1;
      #1 chk("alt_s1", output_data, 32'h5555_5555);

      // Reset applied before any clock.
      rst_n = 1'b0;
      model_reset();
      #1 chk_regs("rst_init");

      clk_en = 1;
      select = 1'b0;
      data0  = 32'h0000_0000;
      data1  = 32'h0000_0000;
      tick("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;

      // Clocked capture.
      data0  = 32'h1111_1111;
      data1  = 32'hDEAD_BEEF;
      select = 1'b1;
      tick("cap1");
      chk("cap1.q_const", output_data_q, 32'hDEAD_BEEF);
      chk("cap1.chg_const", {31'b0, select_changed}, 32'h1);
      tick("cap2");
      chk("cap2.chg_const", {31'b0, select_changed}, 32'h0);

      // Asynchronous reset between clock edges.
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst.q", output_data_q, 32'h0);
      chk("arst.sq", {31'b0, select_q}, 32'h0);
      chk("arst.chg", {31'b0, select_changed}, 32'h0);
      data1 = 32'hCAFE_F00D;
      #1 chk("arst.comb", output_data, 32'hCAFE_F00D);
      tick("arst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      select = 1'b1;
      tick("post_rst");
      chk("post_rst.chg_const", {31'b0, select_changed}, 32'h1);

      // Select toggling every cycle.
      data0 = 32'h1;
      data1 = 32'h2;
      for (int i = 0; i < 4; i++) begin
         select = ~select;
         tick("toggle");
         chk("toggle.chg_const", {31'b0, select_changed}, 32'h1);
         chk("toggle.q_const", output_data_q, (select ? 32'h2 : 32'h1));
      end

      // Random traffic against the model.
      for (int i = 0; i < 200; i++) begin
         data0  = $urandom;
         data1  = ($urandom_range(0, 7) == 0) ? data0 : $urandom;
         select = ($urandom_range(0, 3) == 0) ? select : 1'($urandom_range(0, 1));
         #1 chk("rand.comb", output_data, ref_mux(data0, data1, select));
         if ($urandom_range(0, 49) == 0) begin
            #1;
            rst_n = 1'b0;
            #1;
            model_reset();
            chk_regs("rand.arst");
            @(negedge clk);
            rst_n = 1'b1;
         end
         tick("rand");
      end

      // Unknown select with agreeing operands.
      data0  = 32'h0F0F_0F0F;
      data1  = 32'h0F0F_0F0F;
      select = 1'bx;
      #1 chk("sel_x", output_data, 32'h0F0F_0F0F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
